bsg_cache_to_axi_rx_sched: RTL and testbench
============================================

// Module: bsg_cache_to_axi_rx_sched
// PURPOSE
// Round-robin scheduler feeding the cache-to-AXI read path. Takes block-read
// requests from num_cache_p caches, picks one per issue slot, presents one
// {tag, block-aligned address} request to the AXI read-request/tag-FIFO stage,
// and caps in-flight read bursts at max_outstanding_p using a credit counter.
// PARAMETERS
// num_cache_p            4    number of requesting caches (>=1)
// data_width_p           32   cache DMA word width, bits
// block_size_in_words_p  8    words per cache block (power of 2)
// axi_addr_width_p       32   AXI address width
// max_outstanding_p      num_cache_p  max issued, not-yet-delivered blocks (>=1)
// lg_num_cache_lp        `BSG_SAFE_CLOG2(num_cache_p)  derived; do not override
// PORTS
// clk_i          in   1                   clock
// reset_i        in   1                   asynchronous, active-high reset
// dma_v_i        in   num_cache_p         per-cache read request valid
// dma_addr_i     in   num_cache_p*axi_addr_width_p  per-cache request address
// dma_yumi_o     out  num_cache_p         one-hot dequeue of the captured request
// rx_v_o         out  1                   request valid to read-request stage
// rx_tag_o       out  lg_num_cache_lp     cache index of request
// rx_axi_addr_o  out  axi_addr_width_p    block-aligned AXI read address
// rx_yumi_i      in   1                   downstream accepted request (valid only with rx_v_o)
// rx_done_i      in   1                   one block fully delivered to a cache
// outstanding_o  out  `BSG_SAFE_CLOG2(max_outstanding_p+1)  in-flight count
// BEHAVIOUR
// - Reset (async assert, clock-synchronous deassert use): state=IDLE, rx_v_o=0,
//   rx_tag_o=0, rx_axi_addr_o=0, outstanding_o=0, rr pointer last_r=num_cache_p-1
//   (cache 0 has first priority); dma_yumi_o=0 while in reset.
// - FSM, 2 states:
//   IDLE: if |dma_v_i and outstanding_o<max_outstanding_p: grant g = first set
//     dma_v_i searching last_r+1, last_r+2, ... wrapping mod num_cache_p; same
//     cycle dma_yumi_o[g]=1 (only that bit), register tag=g and address, last_r<=g,
//     -> ISSUE. Otherwise dma_yumi_o=0, stay.
//   ISSUE: rx_v_o=1, tag/addr held stable; dma_yumi_o=0; on rx_yumi_i -> IDLE.
// - Request latency: capture cycle N, rx_v_o high from N+1; max issue rate one
//   request per 2 cycles. rx_v_o never drops without rx_yumi_i.
// - Address: rx_axi_addr_o = dma_addr_i[g] with low
//   log2(block_size_in_words_p*data_width_p/8) bits forced to 0.
// - Credits: outstanding_o +1 on rx_yumi_i, -1 on rx_done_i, unchanged if both
//   same cycle. Capture gated on outstanding_o<max (a request held in ISSUE is
//   not yet counted; gating in IDLE only, so count never exceeds max).
// - rx_done_i with outstanding_o==0 and no rx_yumi_i: illegal; simulation
//   assertion fires, counter saturates at 0.
// - dma_v_i dropping while not granted: permitted, no effect. A cache's
//   dma_addr_i must be stable while its dma_v_i is high.
// - num_cache_p==1: arbiter degenerates, rx_tag_o constant 0.
// - Reset mid-ISSUE: request discarded, rx_v_o=0 immediately (async), credits 0;
//   the capturing cache already dequeued it -- system-level reset expected.
// TESTING
// 1 Reset, dma_v_i=4'b0000 for 10 cycles -> rx_v_o=0, dma_yumi_o=0, outstanding_o=0.
// 2 dma_v_i=4'b1111 held, rx_yumi_i=1 whenever rx_v_o, rx_done_i after each issue
//   -> grant order 0,1,2,3,0; one issue per 2 cycles; rx_tag_o matches.
// 3 dma_addr_i[2]=32'h0000_105C, block 8x32b -> rx_axi_addr_o=32'h0000_1040, tag=2.
// 4 max_outstanding_p=2, rx_done_i=0, all requesting -> exactly 2 issues, then
//   dma_yumi_o=0 until rx_done_i pulse, then third issue follows.
// 5 rx_yumi_i held 0 for 20 cycles in ISSUE -> rx_v_o/tag/addr stable, no
//   further dma_yumi_o; rx_yumi_i and rx_done_i same cycle -> count unchanged.
// 6 reset_i asserted mid-ISSUE between clock edges -> rx_v_o=0 and
//   outstanding_o=0 before next edge; after release cache 0 wins first.

Source files
------------

// File: rtl/bsg_cache_to_axi_rx_sched.sv
// Round-robin read-request scheduler for the cache-to-AXI read path.
// Picks one cache per issue slot, registers its tag and block-aligned
// address, and caps in-flight read bursts with a credit counter.
module bsg_cache_to_axi_rx_sched #(
    parameter int num_cache_p           = 4,
    parameter int data_width_p          = 32,
    parameter int block_size_in_words_p = 8,
    parameter int axi_addr_width_p      = 32,
    parameter int max_outstanding_p     = num_cache_p,
    localparam int lg_num_cache_lp      = (num_cache_p > 1) ? $clog2(num_cache_p) : 1,
    localparam int outstanding_width_lp = $clog2(max_outstanding_p + 1)
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,

    input  logic [num_cache_p-1:0]                    dma_v_i,
    input  logic [num_cache_p*axi_addr_width_p-1:0]   dma_addr_i,
    output logic [num_cache_p-1:0]                    dma_yumi_o,

    output logic                                      rx_v_o,
    output logic [lg_num_cache_lp-1:0]                rx_tag_o,
    output logic [axi_addr_width_p-1:0]               rx_axi_addr_o,
    input  logic                                      rx_yumi_i,
    input  logic                                      rx_done_i,

    output logic [outstanding_width_lp-1:0]           outstanding_o
);

    localparam int block_offset_lp = $clog2(block_size_in_words_p * data_width_p / 8);
    localparam logic [axi_addr_width_p-1:0] addr_mask_lp =
        {axi_addr_width_p{1'b1}} << block_offset_lp;
    localparam logic [outstanding_width_lp-1:0] max_outstanding_lp =
        outstanding_width_lp'(max_outstanding_p);
    localparam logic [lg_num_cache_lp-1:0] last_reset_lp =
        lg_num_cache_lp'(num_cache_p - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e                             state_q, state_d;
    logic                               rx_v_q, rx_v_d;
    logic [lg_num_cache_lp-1:0]         tag_q, tag_d;
    logic [axi_addr_width_p-1:0]        addr_q, addr_d;
    logic [lg_num_cache_lp-1:0]         last_q, last_d;
    logic [outstanding_width_lp-1:0]    outstanding_q, outstanding_d;

    logic                               grant_found;
    logic [lg_num_cache_lp-1:0]         grant_idx;
    logic [axi_addr_width_p-1:0]        grant_addr;
    logic                               capture;
    logic                               accept;

    // Round-robin search starting just after the last granted cache.
    always_comb begin
        int unsigned idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_addr  = '0;
        for (int unsigned i = 1; i <= num_cache_p; i++) begin
            idx = (32'(last_q) + i) % num_cache_p;
            if (!grant_found && dma_v_i[idx]) begin
                grant_found = 1'b1;
                grant_idx   = lg_num_cache_lp'(idx);
                grant_addr  = dma_addr_i[idx*axi_addr_width_p +: axi_addr_width_p];
            end
        end
    end

    assign capture = (state_q == IDLE) && grant_found && (outstanding_q < max_outstanding_lp);
    assign accept  = rx_v_q && rx_yumi_i;

    // Dequeue strobe to the granted cache in the capture cycle; quiet during reset.
    always_comb begin
        dma_yumi_o = '0;
        if (capture && !reset_i) begin
            dma_yumi_o[grant_idx] = 1'b1;
        end
    end

    // Next-state: capture in IDLE, hold in ISSUE until accepted, credit update.
    always_comb begin
        state_d       = state_q;
        rx_v_d        = rx_v_q;
        tag_d         = tag_q;
        addr_d        = addr_q;
        last_d        = last_q;
        outstanding_d = outstanding_q;

        case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = ISSUE;
                    rx_v_d  = 1'b1;
                    tag_d   = grant_idx;
                    addr_d  = grant_addr & addr_mask_lp;
                    last_d  = grant_idx;
                end
            end
            ISSUE: begin
                if (rx_yumi_i) begin
                    state_d = IDLE;
                    rx_v_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                rx_v_d  = 1'b0;
            end
        endcase

        // Simultaneous issue and completion cancel; completion at zero saturates.
        case ({accept, rx_done_i})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = (outstanding_q == '0) ? '0 : outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // State, registered outputs and credit counter.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            rx_v_q        <= 1'b0;
            tag_q         <= '0;
            addr_q        <= '0;
            last_q        <= last_reset_lp;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            rx_v_q        <= rx_v_d;
            tag_q         <= tag_d;
            addr_q        <= addr_d;
            last_q        <= last_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign rx_v_o        = rx_v_q;
    assign rx_tag_o      = tag_q;
    assign rx_axi_addr_o = addr_q;
    assign outstanding_o = outstanding_q;

    rx_done_needs_credit: assert property (@(posedge clk_i) disable iff (reset_i)
        !(rx_done_i && !accept && (outstanding_q == '0)));

endmodule

// File: tb/tb_bsg_cache_to_axi_rx_sched.sv
// Scoreboard bench for bsg_cache_to_axi_rx_sched: expected tag/address pushed
// when requests are set up, popped when the DUT hands a request downstream.
module tb_bsg_cache_to_axi_rx_sched;

    localparam int NC   = 4;
    localparam int AW   = 32;
    localparam int MAXO = 2;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic [NC-1:0]     dma_v_i;
    logic [NC*AW-1:0]  dma_addr_i;
    logic [NC-1:0]     dma_yumi_o;
    logic              rx_v_o;
    logic [1:0]        rx_tag_o;
    logic [AW-1:0]     rx_axi_addr_o;
    logic              rx_yumi_i;
    logic              rx_done_i;
    logic [1:0]        outstanding_o;

    bsg_cache_to_axi_rx_sched #(
        .num_cache_p          (NC),
        .data_width_p         (32),
        .block_size_in_words_p(8),
        .axi_addr_width_p     (AW),
        .max_outstanding_p    (MAXO)
    ) dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .dma_v_i      (dma_v_i),
        .dma_addr_i   (dma_addr_i),
        .dma_yumi_o   (dma_yumi_o),
        .rx_v_o       (rx_v_o),
        .rx_tag_o     (rx_tag_o),
        .rx_axi_addr_o(rx_axi_addr_o),
        .rx_yumi_i    (rx_yumi_i),
        .rx_done_i    (rx_done_i),
        .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]  tag;
        logic [31:0] addr;
    } exp_t;

    exp_t        sb[$];
    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic        auto_ack, auto_done, done_next, check_gap;
    int          cyc, prev_cap, issued;
    logic [NC-1:0] cap_yumi;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] get_addr(input int c);
        return dma_addr_i[c*AW +: AW];
    endfunction

    task automatic set_addr(input int c, input logic [31:0] a);
        dma_addr_i[c*AW +: AW] = a;
    endtask

    task automatic push_exp(input int c, input logic [31:0] a);
        exp_t e;
        e.tag  = 2'(c);
        e.addr = a;
        sb.push_back(e);
    endtask

    // Called at posedge+1; drives handshake, monitors at negedge, returns at next posedge+1.
    task automatic step(input logic done);
        rx_yumi_i = auto_ack & rx_v_o;
        rx_done_i = done | done_next;
        done_next = 1'b0;
        #4;
        if (dma_yumi_o != '0) begin
            cap_yumi = dma_yumi_o;
            if (check_gap && prev_cap >= 0) check_eq("issue_gap", 64'(cyc - prev_cap), 64'd2);
            prev_cap = cyc;
        end
        if (rx_v_o && rx_yumi_i) begin
            issued++;
            if (sb.size() == 0) begin
                check_eq("sb_unexpected_issue", 64'(rx_tag_o), 64'hFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("rx_tag", 64'(rx_tag_o), 64'(e.tag));
                check_eq("rx_addr", 64'(rx_axi_addr_o), 64'(e.addr));
                check_eq("grant_yumi", 64'(cap_yumi), 64'(4'b0001 << e.tag));
            end
            if (auto_done) done_next = 1'b1;
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic wait_issued(input int target, input int budget);
        int b;
        b = budget;
        while (issued < target && b > 0) begin
            step(1'b0);
            b--;
        end
        if (issued < target) check_eq("issue_timeout", 64'(issued), 64'(target));
    endtask

    task automatic wait_rx_v(input int budget);
        int b;
        b = budget;
        while (!rx_v_o && b > 0) begin
            step(1'b0);
            b--;
        end
        if (!rx_v_o) check_eq("rx_v_timeout", 64'(rx_v_o), 64'd1);
    endtask

    initial begin
        logic       saw, stable;
        logic [1:0] t0;
        logic [31:0] a0;

        reset_i    = 1'b1;
        dma_v_i    = '0;
        dma_addr_i = '0;
        rx_yumi_i  = 1'b0;
        rx_done_i  = 1'b0;
        auto_ack   = 1'b0;
        auto_done  = 1'b0;
        done_next  = 1'b0;
        check_gap  = 1'b0;
        cyc        = 0;
        prev_cap   = -1;
        issued     = 0;
        cap_yumi   = '0;

        // Reset state, then idle with no requests.
        @(posedge clk_i);
        #1;
        check_eq("reset_rx_v", 64'(rx_v_o), 64'd0);
        check_eq("reset_yumi", 64'(dma_yumi_o), 64'd0);
        check_eq("reset_outstanding", 64'(outstanding_o), 64'd0);
        step(1'b0);
        reset_i = 1'b0;
        repeat (10) step(1'b0);
        check_eq("idle_rx_v", 64'(rx_v_o), 64'd0);
        check_eq("idle_yumi", 64'(dma_yumi_o), 64'd0);
        check_eq("idle_outstanding", 64'(outstanding_o), 64'd0);
        check_eq("idle_tag", 64'(rx_tag_o), 64'd0);
        check_eq("idle_addr", 64'(rx_axi_addr_o), 64'd0);

        // Round-robin order 0,1,2,3,0 at one issue per two cycles.
        for (int c = 0; c < NC; c++) set_addr(c, 32'h0000_2000 + 32'(c) * 32'h1000 + 32'h17 + 32'(c));
        for (int c = 0; c < NC; c++) push_exp(c, get_addr(c) & 32'hFFFF_FFE0);
        push_exp(0, get_addr(0) & 32'hFFFF_FFE0);
        auto_ack  = 1'b1;
        auto_done = 1'b1;
        check_gap = 1'b1;
        dma_v_i   = 4'b1111;
        issued    = 0;
        wait_issued(5, 40);
        dma_v_i   = '0;
        check_gap = 1'b0;
        repeat (3) step(1'b0);
        check_eq("rr_outstanding_drained", 64'(outstanding_o), 64'd0);

        // Block alignment of an unaligned request address.
        set_addr(2, 32'h0000_105C);
        push_exp(2, 32'h0000_1040);
        dma_v_i = 4'b0100;
        issued  = 0;
        wait_issued(1, 20);
        dma_v_i = '0;
        repeat (3) step(1'b0);

        // Credit cap: two issues, stall, then one more after a completion.
        auto_done = 1'b0;
        push_exp(3, get_addr(3) & 32'hFFFF_FFE0);
        push_exp(0, get_addr(0) & 32'hFFFF_FFE0);
        dma_v_i = 4'b1111;
        issued  = 0;
        wait_issued(2, 20);
        saw = 1'b0;
        repeat (8) begin
            if (dma_yumi_o != '0) saw = 1'b1;
            step(1'b0);
        end
        check_eq("cap_no_yumi", 64'(saw), 64'd0);
        check_eq("cap_rx_v", 64'(rx_v_o), 64'd0);
        check_eq("cap_outstanding", 64'(outstanding_o), 64'd2);
        push_exp(1, get_addr(1) & 32'hFFFF_FFE0);
        step(1'b1);
        wait_issued(3, 10);
        dma_v_i = '0;
        step(1'b1);
        check_eq("cap_after_done", 64'(outstanding_o), 64'd1);

        // Downstream stall: request held stable, then accept and done together.
        auto_ack = 1'b0;
        push_exp(2, get_addr(2) & 32'hFFFF_FFE0);
        dma_v_i = 4'b1111;
        wait_rx_v(10);
        t0 = rx_tag_o;
        a0 = rx_axi_addr_o;
        stable = 1'b1;
        repeat (20) begin
            step(1'b0);
            if (!rx_v_o || rx_tag_o != t0 || rx_axi_addr_o != a0 || dma_yumi_o != '0) stable = 1'b0;
        end
        check_eq("stall_stable", 64'(stable), 64'd1);
        issued   = 0;
        auto_ack = 1'b1;
        step(1'b1);
        dma_v_i  = '0;
        check_eq("stall_issued", 64'(issued), 64'd1);
        step(1'b0);
        check_eq("yumi_done_same_cycle", 64'(outstanding_o), 64'd1);

        // Asynchronous reset in the middle of ISSUE.
        auto_ack = 1'b0;
        dma_v_i  = 4'b1000;
        wait_rx_v(10);
        #2;
        reset_i = 1'b1;
        #1;
        check_eq("async_rx_v", 64'(rx_v_o), 64'd0);
        check_eq("async_outstanding", 64'(outstanding_o), 64'd0);
        check_eq("async_yumi", 64'(dma_yumi_o), 64'd0);
        dma_v_i = '0;
        @(posedge clk_i);
        #1;
        step(1'b0);
        reset_i  = 1'b0;
        auto_ack = 1'b1;
        push_exp(0, get_addr(0) & 32'hFFFF_FFE0);
        dma_v_i  = 4'b1111;
        issued   = 0;
        wait_issued(1, 10);
        dma_v_i  = '0;
        repeat (3) step(1'b0);
        check_eq("sb_empty", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
